// File: rtl/stream_divider_if.sv
// rtl/stream_divider_if.sv - operand/result handshake bundle for stream_divider
interface stream_divider_if #(
  parameter int A_W = 32,
  parameter int B_W = 16
);
  logic           i_valid;
  logic           i_ready;
  logic [A_W-1:0] i_payload_a;
  logic [B_W-1:0] i_payload_b;
  logic           o_valid;
  logic           o_ready;
  logic [A_W-1:0] o_payload_q;
  logic [B_W-1:0] o_payload_r;
  logic           o_dbz;

  modport slave (
    input  i_valid, i_payload_a, i_payload_b, o_ready,
    output i_ready, o_valid, o_payload_q, o_payload_r, o_dbz
  );

  modport master (
    output i_valid, i_payload_a, i_payload_b, o_ready,
    input  i_ready, o_valid, o_payload_q, o_payload_r, o_dbz
  );
endinterface

// File: rtl/stream_divider.sv
// rtl/stream_divider.sv - sequential radix-2 restoring unsigned divider
module stream_divider #(
  parameter int A_W = 32,
  parameter int B_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  stream_divider_if.slave   s
);
  localparam int CNT_W = (A_W > 1) ? $clog2(A_W) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [A_W-1:0]   a_q, a_d;
  logic [B_W-1:0]   b_q, b_d;
  logic [B_W-1:0]   rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             start_q, start_d;

  logic [B_W:0]     partial;
  logic [B_W:0]     diff;

  // a_q doubles as the dividend shifter and the quotient accumulator.
  assign partial = {rem_q, a_q[A_W-1]};
  assign diff    = partial - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    start_d = start_q;
    case (state_q)
      IDLE: begin
        if (s.i_valid) begin
          if (s.i_payload_b != '0) begin
            a_d     = s.i_payload_a;
            b_d     = s.i_payload_b;
            rem_d   = '0;
            cnt_d   = '0;
            dbz_d   = 1'b0;
            start_d = 1'b1;
            state_d = BUSY;
          end else begin
            a_d     = '1;
            b_d     = '0;
            rem_d   = s.i_payload_a[B_W-1:0];
            dbz_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        // First BUSY cycle is a settle cycle; iterations follow on every edge after it.
        if (start_q) begin
          start_d = 1'b0;
        end else begin
          if (!diff[B_W]) begin
            rem_d = diff[B_W-1:0];
            a_d   = {a_q[A_W-2:0], 1'b1};
          end else begin
            rem_d = partial[B_W-1:0];
            a_d   = {a_q[A_W-2:0], 1'b0};
          end
          if (cnt_q == CNT_W'(A_W - 1)) begin
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        if (s.o_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
      start_q <= start_d;
    end
  end

  assign s.i_ready     = (state_q == IDLE);
  assign s.o_valid     = (state_q == DONE);
  assign s.o_payload_q = a_q;
  assign s.o_payload_r = rem_q;
  assign s.o_dbz       = dbz_q;
endmodule
